// File: rtl/instr_decoder.sv
// ============================================================================
// Module      : instr_decoder
// Description : Registered 6-bit instruction decoder with sticky halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instruction,
  output logic       ce_reg_0,
  output logic       ce_reg_1,
  output logic       ce_reg_2,
  output logic       ce_reg_3,
  output logic       ce_acc,
  output logic       ce_flags,
  output logic       ce_out,
  output logic [1:0] reg_sel,
  output logic [3:0] alu_op,
  output logic [1:0] acc_src,
  output logic       reg_src,
  output logic       halt,
  output logic       illegal
);

  localparam logic [3:0] c_OP_MOV = 4'h0;
  localparam logic [3:0] c_OP_LDA = 4'h1;
  localparam logic [3:0] c_OP_OUT = 4'hC;
  localparam logic [3:0] c_OP_IN  = 4'hD;
  localparam logic [3:0] c_OP_CLR = 4'hE;
  localparam logic [3:0] c_OP_SYS = 4'hF;

  localparam logic [1:0] c_SRC_ALU = 2'b00;
  localparam logic [1:0] c_SRC_REG = 2'b01;
  localparam logic [1:0] c_SRC_EXT = 2'b10;

  logic [3:0] w_opcode;
  logic [1:0] w_d;
  logic [3:0] w_ce_reg;
  logic       w_ce_acc;
  logic       w_ce_flags;
  logic       w_ce_out;
  logic [1:0] w_reg_sel;
  logic [3:0] w_alu_op;
  logic [1:0] w_acc_src;
  logic       w_reg_src;
  logic       w_halt_set;
  logic       w_illegal;

  logic [3:0] r_ce_reg;
  logic       r_ce_acc;
  logic       r_ce_flags;
  logic       r_ce_out;
  logic [1:0] r_reg_sel;
  logic [3:0] r_alu_op;
  logic [1:0] r_acc_src;
  logic       r_reg_src;
  logic       r_halt;
  logic       r_illegal;

  assign w_opcode = instruction[5:2];
  assign w_d      = instruction[1:0];

  always_comb begin
    w_ce_reg   = 4'b0000;
    w_ce_acc   = 1'b0;
    w_ce_flags = 1'b0;
    w_ce_out   = 1'b0;
    w_reg_sel  = w_d;
    w_alu_op   = 4'h0;
    w_acc_src  = c_SRC_ALU;
    w_reg_src  = 1'b0;
    w_halt_set = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      c_OP_MOV: begin
        w_ce_reg = 4'b0001 << w_d;
      end
      c_OP_LDA: begin
        w_ce_acc  = 1'b1;
        w_acc_src = c_SRC_REG;
      end
      // Opcodes 2..B are ALU ops; their ALU code is always opcode minus one
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
        w_ce_acc   = 1'b1;
        w_ce_flags = 1'b1;
        w_acc_src  = c_SRC_ALU;
        w_alu_op   = w_opcode - 4'h1;
      end
      c_OP_OUT: begin
        w_ce_out = 1'b1;
      end
      c_OP_IN: begin
        w_ce_acc  = 1'b1;
        w_acc_src = c_SRC_EXT;
      end
      c_OP_CLR: begin
        w_ce_reg  = 4'b0001 << w_d;
        w_reg_src = 1'b1;
      end
      c_OP_SYS: begin
        w_halt_set = (w_d == 2'b01);
        w_illegal  = w_d[1];
      end
      default: begin
        w_ce_reg = 4'b0000;
      end
    endcase
  end

  // Enables and illegal are masked by the halt state held before this edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ce_reg   <= 4'b0000;
      r_ce_acc   <= 1'b0;
      r_ce_flags <= 1'b0;
      r_ce_out   <= 1'b0;
      r_reg_sel  <= 2'b00;
      r_alu_op   <= 4'h0;
      r_acc_src  <= 2'b00;
      r_reg_src  <= 1'b0;
      r_halt     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_ce_reg   <= w_ce_reg & {4{~r_halt}};
      r_ce_acc   <= w_ce_acc & ~r_halt;
      r_ce_flags <= w_ce_flags & ~r_halt;
      r_ce_out   <= w_ce_out & ~r_halt;
      r_reg_sel  <= w_reg_sel;
      r_alu_op   <= w_alu_op;
      r_acc_src  <= w_acc_src;
      r_reg_src  <= w_reg_src;
      r_halt     <= r_halt | w_halt_set;
      r_illegal  <= w_illegal & ~r_halt;
    end
  end

  assign ce_reg_0 = r_ce_reg[0];
  assign ce_reg_1 = r_ce_reg[1];
  assign ce_reg_2 = r_ce_reg[2];
  assign ce_reg_3 = r_ce_reg[3];
  assign ce_acc   = r_ce_acc;
  assign ce_flags = r_ce_flags;
  assign ce_out   = r_ce_out;
  assign reg_sel  = r_reg_sel;
  assign alu_op   = r_alu_op;
  assign acc_src  = r_acc_src;
  assign reg_src  = r_reg_src;
  assign halt     = r_halt;
  assign illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_instr_decoder.sv
// ============================================================================
// Module      : tb_instr_decoder
// Description : Directed self-checking bench for instr_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] instruction = 6'b000000;
  logic       ce_reg_0, ce_reg_1, ce_reg_2, ce_reg_3;
  logic       ce_acc, ce_flags, ce_out;
  logic [1:0] reg_sel;
  logic [3:0] alu_op;
  logic [1:0] acc_src;
  logic       reg_src, halt, illegal;

  int n_checks = 0;
  int n_fails  = 0;

  // {ce_reg_3..0, ce_acc, ce_flags, ce_out}
  logic [6:0]  ce_all;
  logic [17:0] all_out;
  assign ce_all  = {ce_reg_3, ce_reg_2, ce_reg_1, ce_reg_0, ce_acc, ce_flags, ce_out};
  assign all_out = {ce_all, reg_sel, alu_op, acc_src, reg_src, halt, illegal};

  instr_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .ce_reg_0    (ce_reg_0),
    .ce_reg_1    (ce_reg_1),
    .ce_reg_2    (ce_reg_2),
    .ce_reg_3    (ce_reg_3),
    .ce_acc      (ce_acc),
    .ce_flags    (ce_flags),
    .ce_out      (ce_out),
    .reg_sel     (reg_sel),
    .alu_op      (alu_op),
    .acc_src     (acc_src),
    .reg_src     (reg_src),
    .halt        (halt),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [5:0] ins);
    instruction = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] op;
    logic [1:0] d;
    logic [3:0] exp_reg;
    logic [3:0] exp_alu;

    // Asynchronous reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("reset_async_all", {14'd0, all_out}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    tick(6'b000000);
    chk("mov_r0_ce", {25'd0, ce_all}, 32'h08);
    chk("mov_r0_src", {31'd0, reg_src}, 32'd0);

    tick(6'b000001);
    chk("mov_r1_ce", {25'd0, ce_all}, 32'h10);

    tick(6'b001000);
    chk("add_r0_ce", {25'd0, ce_all}, 32'h06);
    chk("add_r0_alu", {28'd0, alu_op}, 32'd1);
    chk("add_r0_src", {30'd0, acc_src}, 32'd0);
    chk("add_r0_sel", {30'd0, reg_sel}, 32'd0);

    tick(6'b001011);
    chk("add_r3_sel", {30'd0, reg_sel}, 32'd3);
    chk("add_r3_ce", {25'd0, ce_all}, 32'h06);

    tick(6'b000110);
    chk("lda_r2_ce", {25'd0, ce_all}, 32'h04);
    chk("lda_r2_src", {30'd0, acc_src}, 32'd1);
    chk("lda_r2_sel", {30'd0, reg_sel}, 32'd2);

    tick(6'b011111);
    chk("not_alu", {28'd0, alu_op}, 32'd6);
    chk("not_ce", {25'd0, ce_all}, 32'h06);

    tick(6'b101100);
    chk("shr_alu", {28'd0, alu_op}, 32'hA);

    tick(6'b110001);
    chk("out_ce", {25'd0, ce_all}, 32'h01);
    chk("out_sel", {30'd0, reg_sel}, 32'd1);

    tick(6'b110100);
    chk("in_ce", {25'd0, ce_all}, 32'h04);
    chk("in_src", {30'd0, acc_src}, 32'd2);

    tick(6'b111011);
    chk("clr_r3_ce", {25'd0, ce_all}, 32'h40);
    chk("clr_r3_src", {31'd0, reg_src}, 32'd1);

    tick(6'b111100);
    chk("nop_ce", {25'd0, ce_all}, 32'h00);
    chk("nop_flags", {30'd0, halt, illegal}, 32'd0);

    tick(6'b111110);
    chk("illegal_set", {31'd0, illegal}, 32'd1);
    chk("illegal_ce", {25'd0, ce_all}, 32'h00);
    tick(6'b000010);
    chk("illegal_clear", {31'd0, illegal}, 32'd0);
    chk("after_illegal_ce", {25'd0, ce_all}, 32'h20);

    // Sweep every instruction except HALT so halt stays clear
    for (int i = 0; i < 64; i++) begin
      if (i != 61) begin
        tick(i[5:0]);
        op = i[5:2];
        d  = i[1:0];
        exp_reg = (op == 4'h0 || op == 4'hE) ? (4'b0001 << d) : 4'b0000;
        exp_alu = (op >= 4'h2 && op <= 4'hB) ? op - 4'h1 : 4'h0;
        chk($sformatf("sweep_ce_reg_%0d", i), {28'd0, ce_reg_3, ce_reg_2, ce_reg_1, ce_reg_0},
            {28'd0, exp_reg});
        chk($sformatf("sweep_acc_src_ext_%0d", i), {31'd0, acc_src == 2'b10},
            {31'd0, op == 4'hD});
        chk($sformatf("sweep_ce_out_%0d", i), {31'd0, ce_out}, {31'd0, op == 4'hC});
        chk($sformatf("sweep_alu_%0d", i), {28'd0, alu_op}, {28'd0, exp_alu});
        chk($sformatf("sweep_illegal_%0d", i), {31'd0, illegal},
            {31'd0, op == 4'hF && d[1]});
        chk($sformatf("sweep_halt_%0d", i), {31'd0, halt}, 32'd0);
      end
    end

    tick(6'b111101);
    chk("halt_set", {31'd0, halt}, 32'd1);
    chk("halt_ce", {25'd0, ce_all}, 32'h00);

    tick(6'b001000);
    chk("halted_add_ce", {25'd0, ce_all}, 32'h00);
    chk("halted_add_alu", {28'd0, alu_op}, 32'd1);
    chk("halted_sticky", {31'd0, halt}, 32'd1);

    tick(6'b111110);
    chk("halted_illegal", {31'd0, illegal}, 32'd0);

    tick(6'b111001);
    chk("halted_clr_ce", {25'd0, ce_all}, 32'h00);
    chk("halted_clr_src", {31'd0, reg_src}, 32'd1);
    chk("halted_clr_sel", {30'd0, reg_sel}, 32'd1);

    // Mid-cycle reset clears halt without an edge
    #2 rst = 1'b1;
    #1;
    chk("midreset_all", {14'd0, all_out}, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    tick(6'b000011);
    chk("post_reset_ce", {25'd0, ce_all}, 32'h40);
    chk("post_reset_halt", {31'd0, halt}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_decoder.md
# instr_decoder

Registered instruction decoder for the lab accumulator datapath. Each clock it decodes a 6-bit instruction word into register chip-enables, ALU operation, operand selects and status flags, one cycle after the word is presented. It sits between the instruction register and the datapath, and it holds a sticky halt state that freezes all enables until reset.

## Interface
- No parameters. Widths are fixed.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- instruction  in  6  instruction word. [5:2] is the opcode; [1:0] is the register field d.
- ce_reg_0..ce_reg_3  out  1 each  write-enable for general register R0..R3. At most one is high.
- ce_acc  out  1  accumulator write-enable.
- ce_flags  out  1  flag-register write-enable.
- ce_out  out  1  output-port latch enable.
- reg_sel  out  2  read-select for the register file.
- alu_op  out  4  ALU operation code.
- acc_src  out  2  accumulator source: 00 = ALU, 01 = register file, 10 = external input.
- reg_src  out  1  register write data: 0 = ACC, 1 = zero.
- halt  out  1  sticky halt indicator.
- illegal  out  1  one-cycle pulse on an illegal opcode.

## Operation
ALU code map: 0 PASS, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 INC, 8 DEC, 9 SHL, A SHR.

Opcode map:
- 0 MOV: ce_reg_d=1, reg_src=0.
- 1 LDA: ce_acc=1, acc_src=01, reg_sel=d.
- 2–6 ADD, SUB, AND, OR, XOR: ce_acc=1, ce_flags=1, acc_src=00, reg_sel=d, alu_op = 1–5 respectively.
- 7 NOT: alu_op=6. Same enables as 2–6; d is ignored.
- 8–B INC, DEC, SHL, SHR: alu_op = 7–A. Same enables as 2–6; d is ignored.
- C OUT: ce_out=1, reg_sel=d.
- D IN: ce_acc=1, acc_src=10.
- E CLR: ce_reg_d=1, reg_src=1.
- F with d=00, NOP: no enables.
- F with d=01, HALT: no enables; sets halt.
- F with d=1x: illegal=1 for one cycle; no enables.

Default values for every field not listed above: all ce_* = 0, reg_sel = d, alu_op = 0, acc_src = 00, reg_src = 0.

Halt behaviour:
- Once halt=1, every ce_* and illegal output is forced to 0 on all following cycles, whatever the instruction.
- reg_sel, alu_op, acc_src and reg_src keep decoding normally while halted.
- Only rst clears halt.

Illegal behaviour: illegal is not sticky. Decoding continues normally on the next cycle.

## Timing
- Every output is a flip-flop updated on the rising edge of clk. The decode of the instruction sampled at edge N is visible after edge N.
- Latency is 1 cycle. Throughput is one instruction per cycle.
- The HALT instruction itself produces halt=1 in the same registered cycle as its decode, with all enables 0.
- Reset:
  - While rst=1, every output is 0 immediately, without waiting for a clock edge: ce_* = 0, reg_sel = 00, alu_op = 0, acc_src = 00, reg_src = 0, halt = 0, illegal = 0.
  - The first decode happens on the first rising edge after rst falls.
  - A reset mid-stream discards the pending decode.
- If instruction changes between edges, only the value sampled at the edge matters.
- HALT followed by an illegal opcode: illegal stays 0, because halt suppresses it.

## Test plan
- Reset: assert rst with instruction=000000 and no clock edge → all outputs 0 at once. Release rst, clock → ce_reg_0=1, reg_src=0, all other enables 0.
- instruction=000001 → after the next edge: ce_reg_1=1, ce_reg_0/2/3=0, ce_acc=0.
- instruction=001000 (ADD R0) → ce_acc=1, ce_flags=1, alu_op=1, acc_src=00, reg_sel=00. Then 001011 → reg_sel=11, same enables.
- instruction=111100 (NOP) → all ce_*=0, halt=0, illegal=0. Then 111110 → illegal=1 for exactly one cycle. Then 000010 → ce_reg_2=1, illegal=0.
- instruction=111101 (HALT) → halt=1. Then 001000 → ce_acc=0, ce_flags=0, alu_op=1, halt stays 1. Assert rst mid-cycle → halt=0 asynchronously.
- Sweep all 64 instruction values with halt clear → exactly one ce_reg_* high for opcodes 0 and E only; acc_src=10 only for opcode D; ce_out only for opcode C.
